// File: rtl/ccff_loader.sv
// Serial loader for a configuration flip-flop (CCFF) chain: takes bitstream bytes
// and shifts CHAIN_LEN bits LSB-first into the chain head, tracking tail parity.
module ccff_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       cfg_valid,
  output logic       tail_parity,
  output logic [1:0] dbg_state
);

  // dbg_state encoding: 0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LEN16 = 16'(CHAIN_LEN);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        parity_q, parity_d;
  logic        cfg_valid_q, cfg_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= 8'd0;
      rem_q       <= 16'd0;
      bcnt_q      <= 4'd0;
      parity_q    <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      bcnt_q      <= bcnt_d;
      parity_q    <= parity_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  // Handshake: a byte transfers on a rising edge where din_valid && din_ready;
  // din_ready depends only on state, and abort in the same cycle wins over the transfer.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    bcnt_d      = bcnt_q;
    parity_d    = parity_q;
    cfg_valid_d = cfg_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          rem_d       = LEN16;
          bcnt_d      = 4'd0;
          shreg_d     = 8'd0;
          parity_d    = 1'b0;
          cfg_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          cfg_valid_d = 1'b0;
        end else if (din_valid) begin
          state_d = ST_SHIFT;
          shreg_d = din;
          // A short final byte only contributes its low rem_q bits.
          bcnt_d  = (rem_q >= 16'd8) ? 4'd8 : rem_q[3:0];
        end
      end
      ST_SHIFT: begin
        shreg_d  = {1'b0, shreg_q[7:1]};
        rem_d    = rem_q - 16'd1;
        bcnt_d   = bcnt_q - 4'd1;
        parity_d = parity_q ^ ccff_tail;
        if (abort) begin
          state_d     = ST_IDLE;
          cfg_valid_d = 1'b0;
        end else if (rem_q == 16'd1) begin
          state_d     = ST_DONE;
          cfg_valid_d = 1'b1;
        end else if (bcnt_q == 4'd1) begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign din_ready     = (state_q == ST_LOAD);
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign ccff_head     = (state_q == ST_SHIFT) & shreg_q[0];
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done          = (state_q == ST_DONE);
  assign cfg_valid     = cfg_valid_q;
  assign tail_parity   = parity_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: three instances (CHAIN_LEN 12, 13, 64) driven one at a
// time and checked against a bit-list reference built from the loaded bytes.
`timescale 1ns/1ps
module tb_ccff_loader;
  localparam int NU = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NU-1:0]       start, abort, din_valid, tail;
  logic [NU-1:0][7:0]  din;
  logic [NU-1:0]       din_ready, head, shen, busy, done, cfgv, par;
  logic [NU-1:0][1:0]  dbg;

  int   total = 0;
  int   bad = 0;
  int   active_u = 0;
  int   shift_cnt = 0;
  int   done_cnt = 0;
  logic par_model = 1'b0;
  bit   tail_one = 1'b0;
  logic got_q[$];
  logic [7:0] bytes_q[$];

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .din(din[0]),
    .din_valid(din_valid[0]), .din_ready(din_ready[0]), .ccff_head(head[0]),
    .ccff_shift_en(shen[0]), .ccff_tail(tail[0]), .busy(busy[0]), .done(done[0]),
    .cfg_valid(cfgv[0]), .tail_parity(par[0]), .dbg_state(dbg[0]));
  ccff_loader #(.CHAIN_LEN(13)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .din(din[1]),
    .din_valid(din_valid[1]), .din_ready(din_ready[1]), .ccff_head(head[1]),
    .ccff_shift_en(shen[1]), .ccff_tail(tail[1]), .busy(busy[1]), .done(done[1]),
    .cfg_valid(cfgv[1]), .tail_parity(par[1]), .dbg_state(dbg[1]));
  ccff_loader u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .din(din[2]),
    .din_valid(din_valid[2]), .din_ready(din_ready[2]), .ccff_head(head[2]),
    .ccff_shift_en(shen[2]), .ccff_tail(tail[2]), .busy(busy[2]), .done(done[2]),
    .cfg_valid(cfgv[2]), .tail_parity(par[2]), .dbg_state(dbg[2]));

  function automatic int len_of(input int u);
    case (u)
      0: return 12;
      1: return 13;
      default: return 64;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change at negedge+1; the monitor samples at negedge, before that.
  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    for (int u = 0; u < NU; u++) tail[u] = tail_one ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (shen[active_u]) begin
        got_q.push_back(head[active_u]);
        par_model ^= tail[active_u];
        shift_cnt++;
      end else begin
        chk("head_quiet", 32'(head[active_u]), 32'd0);
      end
      if (done[active_u]) done_cnt++;
    end
  end

  task automatic arm(input int u);
    active_u  = u;
    got_q.delete();
    par_model = 1'b0;
    shift_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic chk_all_zero();
    for (int u = 0; u < NU; u++) begin
      chk("rst_ready", 32'(din_ready[u]), 32'd0);
      chk("rst_head",  32'(head[u]),      32'd0);
      chk("rst_shen",  32'(shen[u]),      32'd0);
      chk("rst_busy",  32'(busy[u]),      32'd0);
      chk("rst_done",  32'(done[u]),      32'd0);
      chk("rst_cfgv",  32'(cfgv[u]),      32'd0);
      chk("rst_par",   32'(par[u]),       32'd0);
      chk("rst_state", 32'(dbg[u]),       32'd0);
    end
  endtask

  task automatic fill_random(input int u);
    bytes_q.delete();
    for (int i = 0; i < (len_of(u) + 7) / 8; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Loads bytes_q into unit u and checks the complete transaction.
  task automatic run_load(input int u, input int gap, input bit poke);
    int len, budget, idx;
    logic [7:0] b;
    logic xp, gv;
    len = len_of(u);
    arm(u);
    tick_n();
    start[u] = 1'b1;
    tick_n();
    start[u] = 1'b0;
    chk("start_cfgv", 32'(cfgv[u]), 32'd0);
    chk("start_par",  32'(par[u]),  32'd0);
    chk("start_busy", 32'(busy[u]), 32'd1);
    idx = 0;
    foreach (bytes_q[i]) begin
      budget = 0;
      while (!din_ready[u] && budget < 40) begin
        tick_n();
        budget++;
      end
      chk("ready_wait", 32'(din_ready[u]), 32'd1);
      for (int g = 0; g < gap; g++) begin
        chk("stall_ready", 32'(din_ready[u]), 32'd1);
        chk("stall_shen",  32'(shen[u]),      32'd0);
        chk("stall_busy",  32'(busy[u]),      32'd1);
        chk("stall_prog",  32'(shift_cnt),    32'(idx * 8));
        tick_n();
      end
      din[u] = bytes_q[i];
      din_valid[u] = 1'b1;
      tick_n();
      din_valid[u] = 1'b0;
      din[u] = 8'($urandom_range(0, 255));
      if (poke && idx == 0) begin
        start[u] = 1'b1;
        din_valid[u] = 1'b1;
        tick_n();
        start[u] = 1'b0;
        din_valid[u] = 1'b0;
      end
      idx++;
    end
    budget = 0;
    while (!done[u] && budget < 40) begin
      tick_n();
      budget++;
    end
    chk("done_seen",   32'(done[u]),  32'd1);
    chk("done_cfgv",   32'(cfgv[u]),  32'd1);
    chk("done_busy",   32'(busy[u]),  32'd0);
    chk("shift_count", 32'(shift_cnt), 32'(len));
    chk("parity", 32'(par[u]), tail_one ? 32'(len % 2) : 32'(par_model));
    for (int i = 0; i < len; i++) begin
      b  = bytes_q[i / 8];
      xp = b[i % 8];
      gv = (i < got_q.size()) ? got_q[i] : 1'bx;
      chk("head_bit", 32'(gv), 32'(xp));
    end
    tick_n();
    chk("done_pulse", 32'(done[u]),      32'd0);
    chk("done_once",  32'(done_cnt),     32'd1);
    chk("cfg_hold",   32'(cfgv[u]),      32'd1);
    chk("idle_ready", 32'(din_ready[u]), 32'd0);
  endtask

  function automatic logic [11:0] got_vec12();
    logic [11:0] v;
    v = 12'd0;
    for (int i = 0; i < 12; i++) if (i < got_q.size()) v[i] = got_q[i];
    return v;
  endfunction

  initial begin
    int budget;
    start = '0; abort = '0; din_valid = '0; din = '0; tail = '0;
    #1;
    chk_all_zero();
    repeat (3) tick_n();
    rst_n = 1'b1;

    // Known bitstream: A5 then 03 (upper nibble of the second byte ignored).
    bytes_q.delete(); bytes_q.push_back(8'hA5); bytes_q.push_back(8'h03);
    run_load(0, 0, 1'b0);
    chk("seq_a5_03", 32'(got_vec12()), 32'h3A5);
    bytes_q.delete(); bytes_q.push_back(8'hA5); bytes_q.push_back(8'hF3);
    run_load(0, 0, 1'b0);
    chk("seq_a5_f3", 32'(got_vec12()), 32'h3A5);

    // Long stall in LOAD.
    fill_random(0);
    run_load(0, 20, 1'b0);

    // Tail tied high: parity equals chain length parity.
    tail_one = 1'b1;
    fill_random(0); run_load(0, 1, 1'b0);
    fill_random(1); run_load(1, 0, 1'b0);
    tail_one = 1'b0;

    for (int k = 0; k < 8; k++) begin
      int u;
      u = $urandom_range(0, NU - 1);
      fill_random(u);
      run_load(u, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Abort on the 5th shift cycle.
    arm(2);
    start[2] = 1'b1; tick_n(); start[2] = 1'b0;
    din[2] = 8'($urandom_range(0, 255)); din_valid[2] = 1'b1; tick_n(); din_valid[2] = 1'b0;
    budget = 0;
    while (shift_cnt < 5 && budget < 20) begin
      tick_n();
      budget++;
    end
    chk("abort_reach", 32'(shift_cnt), 32'd5);
    abort[2] = 1'b1;
    tick_n();
    abort[2] = 1'b0;
    chk("abort_shen",  32'(shen[2]),   32'd0);
    chk("abort_busy",  32'(busy[2]),   32'd0);
    chk("abort_cfgv",  32'(cfgv[2]),   32'd0);
    chk("abort_ready", 32'(din_ready[2]), 32'd0);
    repeat (3) tick_n();
    chk("abort_nodone", 32'(done_cnt), 32'd0);
    chk("abort_shifts", 32'(shift_cnt), 32'd5);
    fill_random(2);
    run_load(2, 0, 1'b0);

    // Abort wins over a byte offered in the same cycle.
    arm(1);
    start[1] = 1'b1; tick_n(); start[1] = 1'b0;
    din[1] = 8'hFF; din_valid[1] = 1'b1; abort[1] = 1'b1;
    tick_n();
    din_valid[1] = 1'b0; abort[1] = 1'b0;
    chk("prio_busy", 32'(busy[1]), 32'd0);
    chk("prio_cfgv", 32'(cfgv[1]), 32'd0);
    repeat (3) tick_n();
    chk("prio_shifts", 32'(shift_cnt), 32'd0);
    fill_random(1);
    run_load(1, 0, 1'b0);

    // Abort while idle leaves the configuration valid.
    abort[1] = 1'b1; tick_n(); tick_n(); abort[1] = 1'b0;
    chk("idle_abort_cfgv", 32'(cfgv[1]), 32'd1);

    // Asynchronous reset in the middle of a shift.
    arm(0);
    start[0] = 1'b1; tick_n(); start[0] = 1'b0;
    din[0] = 8'h5A; din_valid[0] = 1'b1; tick_n(); din_valid[0] = 1'b0;
    tick_n(); tick_n();
    chk("pre_rst_shen", 32'(shen[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    tick_n();
    rst_n = 1'b1;
    fill_random(0);
    run_load(0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
